// File: rtl/fifo_tb_pkg.sv
// fifo_tb_pkg: fail-cause codes and default sizes shared by the FIFO bench, scoreboard and logger
package fifo_tb_pkg;
  localparam int DEF_DW = 8;
  localparam int DEF_DEPTH = 16;
  localparam logic [1:0] FAIL_NONE = 2'b00;
  localparam logic [1:0] FAIL_DATA = 2'b01;
  localparam logic [1:0] FAIL_FLAG = 2'b10;
  localparam logic [1:0] FAIL_BOTH = 2'b11;
endpackage

// File: rtl/fifo_model_mem.sv
// fifo_model_mem: golden FIFO storage with wrapping pointers, occupancy and registered full/empty
// Ports: i_clk, i_rst_n (sync, active-low); i_wr_en/i_wr_data and i_rd_en are snooped requests;
// o_ar = accepted read this edge; o_head = entry at the read pointer; o_count = occupancy;
// o_full/o_empty = registered model flags.
module fifo_model_mem import fifo_tb_pkg::*; #(
  parameter int DW = DEF_DW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr_en,
  input  logic [DW-1:0]            i_wr_data,
  input  logic                     i_rd_en,
  output logic                     o_ar,
  output logic [DW-1:0]            o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_count, w_count_nx;
  logic r_full, r_empty, w_aw;
  // acceptance is judged against registered model flags, so a full model still accepts a read
  assign w_aw = i_wr_en && !r_full;
  assign o_ar = i_rd_en && !r_empty;
  assign w_count_nx = r_count + (AW+1)'(w_aw) - (AW+1)'(o_ar);
  assign o_head = r_mem[r_rp];
  assign o_count = r_count;
  assign o_full = r_full;
  assign o_empty = r_empty;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
      r_count <= '0;
      r_full <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_aw) r_wp <= r_wp + AW'(1);
      if (o_ar) r_rp <= r_rp + AW'(1);
      r_count <= w_count_nx;
      r_full <= w_count_nx == (AW+1)'(DEPTH);
      r_empty <= w_count_nx == '0;
    end
  end
  always_ff @(posedge i_clk) begin
    if (w_aw) r_mem[r_wp] <= i_wr_data;
  end
endmodule

// File: rtl/fifo_scoreboard.sv
// fifo_scoreboard: golden-model checker for a FIFO, emitting pass/fail strobes per compare
// Ports: i_clk, i_rst_n (sync, active-low); i_wr_en/i_wr_data, i_rd_en/i_rd_data,
// i_dut_full/i_dut_empty snooped from the DUT; o_pass_pulse/o_fail_pulse one-cycle strobes;
// o_fail_code cause (01 data, 10 flag, 11 both); o_exp_data last expected value;
// o_model_count golden occupancy; o_fail_seen sticky failure.
module fifo_scoreboard import fifo_tb_pkg::*; #(
  parameter int DW = DEF_DW,
  parameter int DEPTH = DEF_DEPTH,
  parameter int RD_LAT = 1,
  parameter int CHECK_FLAGS = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr_en,
  input  logic [DW-1:0]            i_wr_data,
  input  logic                     i_rd_en,
  input  logic [DW-1:0]            i_rd_data,
  input  logic                     i_dut_full,
  input  logic                     i_dut_empty,
  output logic                     o_pass_pulse,
  output logic                     o_fail_pulse,
  output logic [1:0]               o_fail_code,
  output logic [DW-1:0]            o_exp_data,
  output logic [$clog2(DEPTH):0]   o_model_count,
  output logic                     o_fail_seen
);
  logic w_ar, w_full, w_empty, w_cmp_valid, w_derr, w_ferr;
  logic [DW-1:0] w_head, w_cmp_exp;
  logic [1:0] w_code;
  logic r_pass, r_fail, r_seen;
  logic [1:0] r_code;
  logic [DW-1:0] r_exp;
  fifo_model_mem #(.DW(DW), .DEPTH(DEPTH)) u_mem (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_wr_en(i_wr_en),
    .i_wr_data(i_wr_data),
    .i_rd_en(i_rd_en),
    .o_ar(w_ar),
    .o_head(w_head),
    .o_count(o_model_count),
    .o_full(w_full),
    .o_empty(w_empty)
  );
  if (RD_LAT == 0) begin : g_lat0
    assign w_cmp_valid = w_ar;
    assign w_cmp_exp = w_head;
  end else begin : g_lat1
    // head is captured on the accepted read edge and compared one edge later
    logic r_valid_q;
    logic [DW-1:0] r_exp_q;
    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        r_valid_q <= 1'b0;
        r_exp_q <= '0;
      end else begin
        r_valid_q <= w_ar;
        if (w_ar) r_exp_q <= w_head;
      end
    end
    assign w_cmp_valid = r_valid_q;
    assign w_cmp_exp = r_exp_q;
  end
  // flags are checked against the model's pre-update state
  assign w_ferr = (CHECK_FLAGS != 0) && (i_dut_full != w_full || i_dut_empty != w_empty);
  assign w_derr = w_cmp_valid && (i_rd_data != w_cmp_exp);
  assign w_code = (w_derr && w_ferr) ? FAIL_BOTH : w_derr ? FAIL_DATA : w_ferr ? FAIL_FLAG : FAIL_NONE;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pass <= 1'b0;
      r_fail <= 1'b0;
      r_code <= FAIL_NONE;
      r_exp <= '0;
      r_seen <= 1'b0;
    end else begin
      r_pass <= w_cmp_valid && !w_derr && !w_ferr;
      r_fail <= w_derr || w_ferr;
      r_code <= w_code;
      if (w_cmp_valid) r_exp <= w_cmp_exp;
      if (w_derr || w_ferr) r_seen <= 1'b1;
    end
  end
  assign o_pass_pulse = r_pass;
  assign o_fail_pulse = r_fail;
  assign o_fail_code = r_code;
  assign o_exp_data = r_exp;
  assign o_fail_seen = r_seen;
endmodule

// File: tb/tb_fifo_scoreboard.sv
// tb_fifo_scoreboard: randomized scoreboard bench for fifo_scoreboard against a queue-based model
module tb_fifo_scoreboard;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_en = 1'b0;
  logic rd_en = 1'b0;
  logic dut_full = 1'b0;
  logic dut_empty = 1'b1;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] rd_data = '0;
  logic pass_pulse, fail_pulse, fail_seen;
  logic [1:0] fail_code;
  logic [DW-1:0] exp_data;
  logic [$clog2(DEPTH):0] model_count;
  typedef struct {
    int cyc;
    logic pass;
    logic fail;
    logic [1:0] code;
    logic [DW-1:0] exp;
  } exp_t;
  exp_t sb[$];
  logic [DW-1:0] ref_q[$];
  logic pend_v = 1'b0;
  logic [DW-1:0] pend_exp = '0;
  logic [DW-1:0] exp_hold = '0;
  logic seen = 1'b0;
  int cyc = 0;
  int total = 0;
  int passed = 0;
  fifo_scoreboard #(.DW(DW), .DEPTH(DEPTH), .RD_LAT(1), .CHECK_FLAGS(1)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_wr_en(wr_en),
    .i_wr_data(wr_data),
    .i_rd_en(rd_en),
    .i_rd_data(rd_data),
    .i_dut_full(dut_full),
    .i_dut_empty(dut_empty),
    .o_pass_pulse(pass_pulse),
    .o_fail_pulse(fail_pulse),
    .o_fail_code(fail_code),
    .o_exp_data(exp_data),
    .o_model_count(model_count),
    .o_fail_seen(fail_seen)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
  endtask
  // reference model: a plain queue of stored bytes plus the one pending read-data compare
  always @(posedge clk) begin
    logic mf, me, ferr, derr, ar, aw;
    cyc++;
    if (!rst_n) begin
      ref_q.delete();
      pend_v = 1'b0;
      exp_hold = '0;
      seen = 1'b0;
    end else begin
      mf = ref_q.size() == DEPTH;
      me = ref_q.size() == 0;
      ferr = (dut_full !== mf) || (dut_empty !== me);
      derr = pend_v && (rd_data !== pend_exp);
      if (pend_v) exp_hold = pend_exp;
      if (pend_v || ferr) begin
        seen = seen | derr | ferr;
        sb.push_back('{cyc, pend_v && !derr && !ferr, derr || ferr, {ferr, derr}, exp_hold});
      end
      ar = rd_en && !me;
      aw = wr_en && !mf;
      pend_v = ar;
      if (ar) pend_exp = ref_q.pop_front();
      if (aw) ref_q.push_back(wr_data);
    end
  end
  // monitor: pops an expectation whenever one is due, otherwise demands silence
  always @(negedge clk) begin
    exp_t e;
    chk("model_count", 32'(model_count), 32'(ref_q.size()));
    chk("exp_data", 32'(exp_data), 32'(exp_hold));
    chk("fail_seen", 32'(fail_seen), 32'(seen));
    chk("pass_fail_excl", 32'(pass_pulse && fail_pulse), 32'(0));
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      chk("pass_pulse", 32'(pass_pulse), 32'(e.pass));
      chk("fail_pulse", 32'(fail_pulse), 32'(e.fail));
      if (e.fail) chk("fail_code", 32'(fail_code), 32'(e.code));
      chk("cmp_exp_data", 32'(exp_data), 32'(e.exp));
    end else begin
      chk("no_pulse", 32'({pass_pulse, fail_pulse}), 32'(0));
    end
  end
  // bf[0] corrupts dut_full, bf[1] corrupts dut_empty; bd flips the read-data LSB
  task automatic drive(input logic rst, input logic wr, input logic [DW-1:0] wd,
                       input logic rd, input logic bd, input logic [1:0] bf);
    @(negedge clk);
    rst_n = rst;
    wr_en = wr;
    wr_data = wd;
    rd_en = rd;
    rd_data = pend_v ? (pend_exp ^ DW'(bd)) : DW'($urandom);
    dut_full = (ref_q.size() == DEPTH) ^ bf[0];
    dut_empty = (ref_q.size() == 0) ^ bf[1];
  endtask
  task automatic idle_zero_check();
    @(posedge clk);
    #1;
    chk("rst_outputs", 32'({pass_pulse, fail_pulse, fail_code, exp_data, fail_seen}), 32'(0));
    chk("rst_count", 32'(model_count), 32'(0));
  endtask
  initial begin
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 2'b00);
    idle_zero_check();
    drive(1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 2'b00);
    drive(1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 2'b00);
    drive(1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, '0, 1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 2'b00);
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b1, DW'(8'h40 + i), 1'b0, 1'b0, 2'b00);
    drive(1'b1, 1'b1, 8'hEE, 1'b0, 1'b0, 2'b00);
    drive(1'b1, 1'b1, 8'h99, 1'b1, 1'b0, 2'b00);
    for (int i = 0; i < DEPTH + 2; i++) drive(1'b1, 1'b0, '0, 1'b1, 1'b0, 2'b00);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 2'b00);
    drive(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 2'b00);
    drive(1'b1, 1'b0, '0, 1'b1, 1'b0, 2'b00);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1, 2'b00);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 2'b00);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 2'b10);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 2'b00);
    drive(1'b1, 1'b1, 8'h5C, 1'b0, 1'b0, 2'b00);
    drive(1'b1, 1'b0, '0, 1'b1, 1'b0, 2'b00);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1, 2'b01);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 2'b00);
    drive(1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 2'b00);
    drive(1'b1, 1'b0, '0, 1'b1, 1'b0, 2'b00);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 2'b00);
    idle_zero_check();
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 99) != 0, $urandom_range(0, 3) < (i < 200 ? 3 : 1), DW'($urandom),
            $urandom_range(0, 3) < (i < 200 ? 1 : 3), $urandom_range(0, 19) == 0,
            ($urandom_range(0, 29) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
